// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, response and ALU-side signals of the shared-ALU arbiter
// slave  = arbiter side: takes requests and alu_result, drives readies, ALU operands and responses
// master = environment side: requesters, response consumers and the ALU itself
interface alu_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
  logic [2:0]       alu_control;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;
  logic             busy;
  modport slave (
    input  req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2, req0_op, req1_op,
    input  alu_result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_in1, alu_in2, alu_control,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_err, busy
  );
  modport master (
    output req0_valid, req1_valid, req0_in1, req0_in2, req1_in1, req1_in2, req0_op, req1_op,
    output alu_result, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_in1, alu_in2, alu_control,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one single-cycle ALU between two valid/ready requesters
// clk, reset : rising-edge clock, synchronous active-high reset
// bus        : alu_arbiter_if.slave (request channels, registered ALU inputs, held response channel, busy)
module alu_arbiter #(parameter int WIDTH = 32) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t           state;
  logic             last_grant, owner, grant0, grant1, illegal, rsp_done;
  logic [WIDTH-1:0] sel_in1, sel_in2;
  logic [2:0]       sel_op;
  // On a tie the requester that did not win last time gets the grant
  always_comb begin
    grant0   = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1   = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    sel_in1  = grant1 ? bus.req1_in1 : bus.req0_in1;
    sel_in2  = grant1 ? bus.req1_in2 : bus.req0_in2;
    sel_op   = grant1 ? bus.req1_op : bus.req0_op;
    illegal  = &sel_op[2:1];
    rsp_done = owner ? bus.rsp1_ready : bus.rsp0_ready;
  end
  assign bus.req0_ready = (state == IDLE) & grant0;
  assign bus.req1_ready = (state == IDLE) & grant1;
  assign bus.busy       = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      bus.alu_in1     <= '0;
      bus.alu_in2     <= '0;
      bus.alu_control <= 3'b000;
      bus.rsp_result  <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp0_valid  <= 1'b0;
      bus.rsp1_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          owner      <= grant1;
          last_grant <= grant1;
          // Illegal opcodes bypass the ALU and answer immediately with an error
          if (illegal) begin
            bus.rsp_result <= '0;
            bus.rsp_err    <= 1'b1;
            bus.rsp0_valid <= grant0;
            bus.rsp1_valid <= grant1;
            state          <= RESP;
          end else begin
            bus.alu_in1     <= sel_in1;
            bus.alu_in2     <= sel_in2;
            bus.alu_control <= sel_op;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          bus.rsp_result <= bus.alu_result;
          bus.rsp_err    <= 1'b0;
          bus.rsp0_valid <= ~owner;
          bus.rsp1_valid <= owner;
          state          <= RESP;
        end
        RESP: if (rsp_done) begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  alu_arbiter_if #(.WIDTH(32)) bus();
  alu_arbiter #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        err;
  } exp_t;
  exp_t sb[$];
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b101:  return a + b;
      3'b100:  return a - b;
      3'b010:  return a << b;
      3'b011:  return a >> b;
      default: return 32'h0;
    endcase
  endfunction
  always_comb bus.alu_result = alu_fn(bus.alu_in1, bus.alu_in2, bus.alu_control);
  function automatic exp_t mk(logic o, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    exp_t e;
    e.owner = o;
    e.err   = op[2] & op[1];
    e.res   = e.err ? 32'h0 : alu_fn(a, b, op);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Handshakes are sampled mid-cycle; inputs only change just after posedge
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.req0_valid && bus.req0_ready) sb.push_back(mk(1'b0, bus.req0_in1, bus.req0_in2, bus.req0_op));
      if (bus.req1_valid && bus.req1_ready) sb.push_back(mk(1'b1, bus.req1_in1, bus.req1_in2, bus.req1_op));
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_owner", {31'b0, bus.rsp1_valid}, {31'b0, e.owner});
          chk("rsp_result", bus.rsp_result, e.res);
          chk("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = 1'b1;
    bus.req0_op = op;
    bus.req0_in1 = a;
    bus.req0_in2 = b;
  endtask
  task automatic set1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = 1'b1;
    bus.req1_op = op;
    bus.req1_in1 = a;
    bus.req1_in2 = b;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask
  task automatic drain;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    tick();
    chk("drain", sb.size(), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int acc_c[$];
    logic acc_o[$];
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_op = 0; bus.req1_op = 0;
    bus.req0_in1 = 0; bus.req0_in2 = 0; bus.req1_in1 = 0; bus.req1_in2 = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_alu_in2", bus.alu_in2, 0);
    chk("rst_alu_ctl", {29'b0, bus.alu_control}, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 0);
    chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 0);
    chk("rst_req0_ready", {31'b0, bus.req0_ready}, 0);
    chk("rst_req1_ready", {31'b0, bus.req1_ready}, 0);
    chk("rst_busy", {31'b0, bus.busy}, 0);
    tick();
    reset = 1'b0;
    // single add
    set0(3'b101, 32'h5, 32'h3);
    bus.rsp0_ready = 1;
    @(negedge clk);
    chk("add_ready", {31'b0, bus.req0_ready}, 1);
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("add_alu_ctl", {29'b0, bus.alu_control}, 32'h5);
    chk("add_alu_in1", bus.alu_in1, 32'h5);
    chk("add_early_rsp", {31'b0, bus.rsp0_valid}, 0);
    chk("add_busy", {31'b0, bus.busy}, 1);
    @(negedge clk);
    chk("add_rsp0_valid", {31'b0, bus.rsp0_valid}, 1);
    chk("add_result", bus.rsp_result, 32'h8);
    chk("add_err", {31'b0, bus.rsp_err}, 0);
    chk("add_rsp1_valid", {31'b0, bus.rsp1_valid}, 0);
    drain();
    // tie round robin from fresh reset
    do_reset();
    set0(3'b100, 32'h10, 32'h4);
    set1(3'b010, 32'h1, 32'h4);
    bus.rsp1_ready = 1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (bus.req0_ready) begin acc_c.push_back(c); acc_o.push_back(1'b0); end
      if (bus.req1_ready) begin acc_c.push_back(c); acc_o.push_back(1'b1); end
    end
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    chk("tie_count", acc_c.size(), 4);
    for (int i = 0; i < acc_c.size(); i++) begin
      chk("tie_order", {31'b0, acc_o[i]}, i % 2);
      if (i > 0) chk("tie_spacing", acc_c[i] - acc_c[i-1], 3);
    end
    drain();
    // backpressure on req1
    set1(3'b011, 32'h8000_0000, 32'd31);
    bus.rsp1_ready = 0;
    @(negedge clk);
    chk("bp_req1_ready", {31'b0, bus.req1_ready}, 1);
    tick();
    bus.req1_valid = 0;
    set0(3'b101, 32'h1, 32'h1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_req0_blocked", {31'b0, bus.req0_ready}, 0);
      if (k > 0) begin
        chk("bp_rsp1_valid", {31'b0, bus.rsp1_valid}, 1);
        chk("bp_rsp_hold", bus.rsp_result, 32'h1);
      end
    end
    tick();
    bus.rsp1_ready = 1;
    @(negedge clk);
    chk("bp_hs_valid", {31'b0, bus.rsp1_valid}, 1);
    chk("bp_hs_no_accept", {31'b0, bus.req0_ready}, 0);
    tick();
    bus.rsp1_ready = 0;
    @(negedge clk);
    chk("bp_req0_after", {31'b0, bus.req0_ready}, 1);
    tick();
    bus.req0_valid = 0;
    drain();
    // illegal opcode
    set0(3'b111, 32'hDEAD, 32'h7);
    @(negedge clk);
    chk("ill_ready", {31'b0, bus.req0_ready}, 1);
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    chk("ill_rsp0_valid", {31'b0, bus.rsp0_valid}, 1);
    chk("ill_err", {31'b0, bus.rsp_err}, 1);
    chk("ill_result", bus.rsp_result, 0);
    chk("ill_alu_in1", bus.alu_in1, 32'h1);
    chk("ill_alu_in2", bus.alu_in2, 32'h1);
    chk("ill_alu_ctl", {29'b0, bus.alu_control}, 32'h5);
    drain();
    // reset during ISSUE
    set1(3'b000, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    bus.rsp1_ready = 1;
    @(negedge clk);
    chk("rmo_req1_ready", {31'b0, bus.req1_ready}, 1);
    tick();
    bus.req1_valid = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rmo_no_rsp1", {31'b0, bus.rsp1_valid}, 0);
      if (k == 0) begin
        chk("rmo_alu_in1", bus.alu_in1, 0);
        chk("rmo_alu_ctl", {29'b0, bus.alu_control}, 0);
        chk("rmo_rsp_result", bus.rsp_result, 0);
        chk("rmo_busy", {31'b0, bus.busy}, 0);
      end
    end
    tick();
    set0(3'b101, 32'h2, 32'h2);
    set1(3'b101, 32'h3, 32'h3);
    bus.rsp0_ready = 1;
    @(negedge clk);
    chk("rmo_tie_req0", {31'b0, bus.req0_ready}, 1);
    chk("rmo_tie_req1", {31'b0, bus.req1_ready}, 0);
    tick();
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    drain();
    // wrong-owner ready is ignored
    set0(3'b001, 32'hF0, 32'h0F);
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 1;
    @(negedge clk);
    chk("wo_ready", {31'b0, bus.req0_ready}, 1);
    tick();
    bus.req0_valid = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("wo_rsp0_held", {31'b0, bus.rsp0_valid}, 1);
        chk("wo_rsp1_low", {31'b0, bus.rsp1_valid}, 0);
        chk("wo_busy", {31'b0, bus.busy}, 1);
      end
    end
    tick();
    bus.rsp0_ready = 1;
    drain();
    chk("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single-cycle 32-bit ALU between two requesters (req0, req1) using valid/ready handshakes. It registers the winning operands and opcode onto the ALU inputs and captures the ALU result one cycle later. It returns the result to the owning requester on a held response channel. Only one operation is outstanding at a time. Opcodes the ALU does not define are rejected with an error response and never reach the ALU.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid & ready
- req0_in1 / req1_in1  in  WIDTH  operand 1
- req0_in2 / req1_in2  in  WIDTH  operand 2
- req0_op / req1_op  in  3  opcode: 000 and, 001 or, 101 add, 100 sub, 010 sll, 011 srl; 110/111 illegal
- alu_in1  out  WIDTH  registered operand 1 to ALU
- alu_in2  out  WIDTH  registered operand 2 to ALU
- alu_control  out  3  registered opcode to ALU
- alu_result  in  WIDTH  combinational ALU result
- rsp0_valid / rsp1_valid  out  1  response for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp_result  out  WIDTH  shared response data, valid only with a rspN_valid
- rsp_err  out  1  1 = illegal opcode, rsp_result = 0
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Grant in IDLE:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant wins.
  - last_grant resets to 1, so req0 wins the first tie.
- reqN_ready = (state==IDLE) & grantN. It depends on valid; valid must not depend on ready. Both readies are 0 outside IDLE.
- IDLE accept, legal op:
  - Latch in1, in2, op into alu_in1, alu_in2, alu_control.
  - Record owner; update last_grant to the owner.
  - Go to ISSUE.
- IDLE accept, illegal op (110/111):
  - ALU registers are unchanged.
  - rsp_result = 0 and rsp_err = 1; record owner; update last_grant.
  - Go to RESP.
- ISSUE: capture alu_result into rsp_result, rsp_err = 0, go to RESP. Exactly one cycle.
- RESP:
  - Assert the owner's rspN_valid only.
  - Hold rsp_result and rsp_err stable until the owner's rspN_ready is high, then go to IDLE.
  - The non-owner's rsp_ready is ignored.
- No request is accepted in the cycle a response completes. Accept is possible again from the next IDLE cycle.
- alu_in1, alu_in2 and alu_control hold their last values in all states. The ALU is never presented an undefined opcode.
- Operands pass unmodified. Shift amount is the full in2 value; width semantics belong to the ALU.
- A requester may drop valid before ready without penalty. There is no request queueing.

## Timing
- Reset values:
  - state IDLE, last_grant 1, owner 0.
  - alu_in1 0, alu_in2 0, alu_control 000.
  - rsp_result 0, rsp_err 0, rsp0_valid 0, rsp1_valid 0.
  - req0_ready 0, req1_ready 0, busy 0.
- Legal op: accept at edge T. ALU inputs are valid during cycle T+1. rspN_valid is high from cycle T+2.
- Illegal op: accept at T; rspN_valid is high from T+1.
- Minimum throughput: one legal op per 3 cycles with rsp_ready tied high; one illegal op per 2 cycles.
- Reset asserted mid-operation (ISSUE or RESP):
  - The in-flight op is discarded and no response is produced.
  - All outputs take reset values at the next edge.
- Reset has priority over every other transition.

## Test plan
- Single add: req0 op 101, in1 0x0000_0005, in2 0x0000_0003, rsp0_ready=1 -> req0_ready in accept cycle; alu_control 101 the next cycle; rsp0_valid 2 cycles after accept with rsp_result 0x0000_0008, rsp_err 0, rsp1_valid 0.
- Tie round-robin: both valid continuously with sub 0x10-0x4 (req0) and sll 0x1<<4 (req1) -> grants in order req0, req1, req0, req1; results alternate 0x0C and 0x10; 3-cycle spacing between accepts.
- Backpressure: req1 srl 0x8000_0000>>31 with rsp1_ready low for 5 cycles -> rsp1_valid and rsp_result 0x0000_0001 held stable; req0_valid high meanwhile sees req0_ready 0; accept of req0 only in the cycle after rsp1 handshake.
- Illegal op: req0 op 111 -> rsp0_valid one cycle after accept, rsp_result 0, rsp_err 1; alu_in1/alu_in2/alu_control unchanged from prior op.
- Reset mid-op: assert reset during ISSUE of req1 and 32'hFFFF_FFFF & 32'h0F0F_0F0F -> no rsp1_valid ever; all outputs at reset values; next tie grants req0.
- Wrong-owner ready: rsp1_ready=1 while owner is req0 with rsp0_ready=0 -> state stays RESP and rsp0_valid stays high.
